uart_rx: RTL and testbench



---
 rtl/uart_rx_if.sv | 26 ++
 rtl/uart_rx.sv | 144 ++++++++++++++
 tb/tb_uart_rx.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Parallel/serial signal bundle of the UART receiver.
// The slave modport is the receiver's view; master is the driving side.
interface uart_rx_if #(
    parameter int width   = 8,
    parameter int presc_w = 6
);
    logic               RX_in;
    logic [presc_w-1:0] Prescale;
    logic               Par_en;
    logic               Par_type;
    logic [width-1:0]   P_data;
    logic               Data_valid;
    logic               Par_err;
    logic               Stp_err;
    logic               Busy;

    modport master (
        output RX_in, Prescale, Par_en, Par_type,
        input  P_data, Data_valid, Par_err, Stp_err, Busy
    );

    modport slave (
        input  RX_in, Prescale, Par_en, Par_type,
        output P_data, Data_valid, Par_err, Stp_err, Busy
    );
endinterface

// File: rtl/uart_rx.sv
// Oversampling UART receiver: majority-of-3 bit sampling, optional parity,
// stop-bit check, one-cycle result pulses.
module uart_rx #(
    parameter int width   = 8,
    parameter int presc_w = 6
) (
    input logic      clk,
    input logic      rst,
    uart_rx_if.slave bus
);
    localparam int cnt_w = $clog2(width + 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t             state;
    logic [1:0]         sync;
    logic               rx_s;
    logic [presc_w-1:0] presc_r;
    logic [presc_w-1:0] edge_cnt;
    logic [presc_w-1:0] half;
    logic [presc_w-1:0] smp_lo;
    logic [presc_w-1:0] smp_hi;
    logic [presc_w-1:0] last_cnt;
    logic               par_en_r;
    logic               par_type_r;
    logic [cnt_w-1:0]   bit_cnt;
    logic [width-1:0]   shift_r;
    logic [width-1:0]   p_data_r;
    logic               smp_a;
    logic               smp_b;
    logic               bit_val;
    logic               par_flag;
    logic               maj;
    logic               at_end;
    logic               at_decide;
    logic               data_valid_r;
    logic               par_err_r;
    logic               stp_err_r;

    assign rx_s      = sync[1];
    assign half      = {1'b0, presc_r[presc_w-1:1]};
    assign smp_lo    = half - presc_w'(1);
    assign smp_hi    = half + presc_w'(1);
    assign last_cnt  = presc_r - presc_w'(1);
    assign at_decide = (edge_cnt == smp_hi);
    assign at_end    = (edge_cnt == last_cnt);
    // Third sample is the live synchronized value, so the decision is ready at P/2+1.
    assign maj       = (smp_a & smp_b) | (smp_a & rx_s) | (smp_b & rx_s);

    // NOTE: every register uses <= so all branches see pre-edge values of state and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync         <= 2'b11;
            state        <= IDLE;
            presc_r      <= '0;
            edge_cnt     <= '0;
            par_en_r     <= 1'b0;
            par_type_r   <= 1'b0;
            bit_cnt      <= '0;
            shift_r      <= '0;
            p_data_r     <= '0;
            smp_a        <= 1'b1;
            smp_b        <= 1'b1;
            bit_val      <= 1'b1;
            par_flag     <= 1'b0;
            data_valid_r <= 1'b0;
            par_err_r    <= 1'b0;
            stp_err_r    <= 1'b0;
        end else begin
            sync         <= {sync[0], bus.RX_in};
            data_valid_r <= 1'b0;
            par_err_r    <= 1'b0;
            stp_err_r    <= 1'b0;

            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        // Frame format is frozen here; later input changes wait for the next frame.
                        presc_r    <= bus.Prescale;
                        par_en_r   <= bus.Par_en;
                        par_type_r <= bus.Par_type;
                        par_flag   <= 1'b0;
                        bit_cnt    <= '0;
                        edge_cnt   <= presc_w'(1);
                        state      <= START;
                    end
                end
                default: begin
                    edge_cnt <= at_end ? '0 : edge_cnt + presc_w'(1);
                    if (edge_cnt == smp_lo) smp_a <= rx_s;
                    if (edge_cnt == half)   smp_b <= rx_s;
                    if (at_decide)          bit_val <= maj;

                    case (state)
                        START: begin
                            if (at_decide && maj) begin
                                edge_cnt <= '0;
                                state    <= IDLE;
                            end else if (at_end) begin
                                state <= DATA;
                            end
                        end
                        DATA: begin
                            if (at_end) begin
                                shift_r <= {bit_val, shift_r[width-1:1]};
                                if (bit_cnt == cnt_w'(width - 1)) begin
                                    bit_cnt <= '0;
                                    state   <= par_en_r ? PARITY : STOP;
                                end else begin
                                    bit_cnt <= bit_cnt + cnt_w'(1);
                                end
                            end
                        end
                        PARITY: begin
                            if (at_end) begin
                                par_flag <= bit_val ^ (^shift_r) ^ par_type_r;
                                state    <= STOP;
                            end
                        end
                        STOP: begin
                            if (at_end) begin
                                state <= IDLE;
                                if (par_flag || !bit_val) begin
                                    par_err_r <= par_flag;
                                    stp_err_r <= !bit_val;
                                end else begin
                                    p_data_r     <= shift_r;
                                    data_valid_r <= 1'b1;
                                end
                            end
                        end
                        default: ;
                    endcase
                end
            endcase
        end
    end

    assign bus.P_data     = p_data_r;
    assign bus.Data_valid = data_valid_r;
    assign bus.Par_err    = par_err_r;
    assign bus.Stp_err    = stp_err_r;
    assign bus.Busy       = (state != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: table of frames driven by a bit-level transmitter model,
// a pulse scoreboard with exact cycle expectations, and corner-case sequences.
module tb_uart_rx;
    localparam int width   = 8;
    localparam int presc_w = 6;

    typedef struct {
        logic [7:0] data;
        int         p;
        logic       par_en;
        logic       par_type;
        logic       par_bit;
        logic       stop_bit;
        int         gap;
        int         glitch_bit;
        int         glitch_off;
        logic       dv;
        logic       pe;
        logic       se;
    } vec_t;

    typedef struct {
        int         cyc;
        logic       dv;
        logic       pe;
        logic       se;
        logic [7:0] pdata;
    } exp_t;

    typedef struct {
        int lo;
        int hi;
    } win_t;

    logic       clk = 1'b0;
    logic       rst;
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;
    logic       mon_en = 1'b0;
    logic       busy_chk = 1'b0;
    logic [7:0] last_good = 8'h00;
    exp_t       sb[$];
    win_t       wins[$];
    vec_t       vecs[12];

    uart_rx_if #(.width(width), .presc_w(presc_w)) bus ();

    uart_rx #(.width(width), .presc_w(presc_w)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic busy_exp();
        foreach (wins[i]) if (cyc >= wins[i].lo && cyc <= wins[i].hi) return 1'b1;
        return 1'b0;
    endfunction

    function automatic vec_t mk(input logic [7:0] data, input int p,
                                input logic par_en, input logic par_type,
                                input logic par_bit, input logic stop_bit,
                                input int gap, input int gb, input int go,
                                input logic dv, input logic pe, input logic se);
        vec_t v;
        v.data = data; v.p = p; v.par_en = par_en; v.par_type = par_type;
        v.par_bit = par_bit; v.stop_bit = stop_bit; v.gap = gap;
        v.glitch_bit = gb; v.glitch_off = go; v.dv = dv; v.pe = pe; v.se = se;
        return v;
    endfunction

    // Scoreboard and Busy monitor, sampled mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            while (wins.size() > 0 && wins[0].hi < cyc) void'(wins.pop_front());
            if (busy_chk) check($sformatf("busy@%0d", cyc), 32'(bus.Busy), 32'(busy_exp()));
            if (bus.Data_valid || bus.Par_err || bus.Stp_err) begin
                if (sb.size() == 0) begin
                    check($sformatf("unexpected_pulse@%0d", cyc),
                          32'({bus.Data_valid, bus.Par_err, bus.Stp_err}), 32'(0));
                end else begin
                    e = sb.pop_front();
                    check("pulse_cycle", 32'(cyc), 32'(e.cyc));
                    check($sformatf("data_valid@%0d", cyc), 32'(bus.Data_valid), 32'(e.dv));
                    check($sformatf("par_err@%0d", cyc), 32'(bus.Par_err), 32'(e.pe));
                    check($sformatf("stp_err@%0d", cyc), 32'(bus.Stp_err), 32'(e.se));
                    check($sformatf("p_data@%0d", cyc), 32'(bus.P_data), 32'(e.pdata));
                end
            end
        end
    end

    // Called #1 after a posedge; returns #1 after a posedge.
    task automatic idle(input int n);
        bus.RX_in = 1'b1;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input vec_t v);
        logic bits [0:10];
        int   nb;
        int   c;
        exp_t e;
        win_t w;
        idle(v.gap);
        nb = v.par_en ? 11 : 10;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = v.data[i];
        bits[9]  = v.par_en ? v.par_bit : v.stop_bit;
        bits[10] = v.stop_bit;
        c = cyc;
        bus.Prescale = presc_w'(v.p);
        bus.Par_en   = v.par_en;
        bus.Par_type = v.par_type;
        if (v.dv) last_good = v.data;
        e.cyc = c + 2 + nb * v.p; e.dv = v.dv; e.pe = v.pe; e.se = v.se; e.pdata = last_good;
        sb.push_back(e);
        w.lo = c + 3; w.hi = c + 1 + nb * v.p;
        wins.push_back(w);
        for (int b = 0; b < nb; b++) begin
            for (int k = 0; k < v.p; k++) begin
                bus.RX_in = (b == v.glitch_bit && k == v.glitch_off) ? ~bits[b] : bits[b];
                @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "simulation timed out");
    end

    initial begin
        int         c;
        exp_t       e;
        win_t       w;
        logic [7:0] d55;

        //            data   P  pen ptyp pbit stop gap gbit goff dv pe se
        vecs[0]  = mk(8'hA5,  8, 0, 0, 0, 1, 5, -1, 0, 1, 0, 0);
        vecs[1]  = mk(8'h3C,  8, 1, 0, 0, 1, 3, -1, 0, 1, 0, 0);
        vecs[2]  = mk(8'h3C,  8, 1, 0, 1, 1, 3, -1, 0, 0, 1, 0);
        vecs[3]  = mk(8'h5A,  8, 0, 0, 0, 0, 3, -1, 0, 0, 0, 1);
        vecs[4]  = mk(8'h01, 16, 0, 0, 0, 1, 4, -1, 0, 1, 0, 0);
        vecs[5]  = mk(8'hFF, 16, 0, 0, 0, 1, 0, -1, 0, 1, 0, 0);
        vecs[6]  = mk(8'h01, 16, 0, 0, 0, 1, 4,  4, 8, 1, 0, 0);
        vecs[7]  = mk(8'hFF, 16, 0, 0, 0, 1, 0,  4, 8, 1, 0, 0);
        vecs[8]  = mk(8'h07, 12, 1, 1, 0, 1, 2, -1, 0, 1, 0, 0);
        vecs[9]  = mk(8'h80, 32, 1, 1, 1, 0, 2, -1, 0, 0, 1, 1);
        vecs[10] = mk(8'hFF, 10, 1, 0, 0, 1, 0, -1, 0, 1, 0, 0);
        vecs[11] = mk(8'h96,  8, 1, 1, 1, 1, 0,  2, 3, 1, 0, 0);

        rst          = 1'b1;
        bus.RX_in    = 1'b1;
        bus.Prescale = presc_w'(8);
        bus.Par_en   = 1'b0;
        bus.Par_type = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_p_data", 32'(bus.P_data), 32'(0));
        check("reset_data_valid", 32'(bus.Data_valid), 32'(0));
        check("reset_par_err", 32'(bus.Par_err), 32'(0));
        check("reset_stp_err", 32'(bus.Stp_err), 32'(0));
        check("reset_busy", 32'(bus.Busy), 32'(0));
        rst = 1'b0;
        @(posedge clk);
        #1;
        mon_en   = 1'b1;
        busy_chk = 1'b1;

        foreach (vecs[i]) send_frame(vecs[i]);
        idle(6);

        // False start: line low for 3 clocks only.
        c = cyc;
        bus.Prescale = presc_w'(8);
        bus.Par_en   = 1'b0;
        w.lo = c + 3; w.hi = c + 7;
        wins.push_back(w);
        bus.RX_in = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        idle(5);
        @(negedge clk);
        check("false_start_idle", 32'(bus.Busy), 32'(0));
        @(posedge clk);
        #1;
        idle(5);

        // Break: line low for 100 clocks, then high; second frame decodes as 0xFE.
        c = cyc;
        bus.Prescale = presc_w'(8);
        bus.Par_en   = 1'b0;
        bus.Par_type = 1'b0;
        e.cyc = c + 82; e.dv = 1'b0; e.pe = 1'b0; e.se = 1'b1; e.pdata = last_good;
        sb.push_back(e);
        last_good = 8'hFE;
        e.cyc = c + 162; e.dv = 1'b1; e.pe = 1'b0; e.se = 1'b0; e.pdata = last_good;
        sb.push_back(e);
        w.lo = c + 3;  w.hi = c + 81;  wins.push_back(w);
        w.lo = c + 83; w.hi = c + 161; wins.push_back(w);
        bus.RX_in = 1'b0;
        repeat (100) begin
            @(posedge clk);
            #1;
        end
        idle(80);

        // Reset during data bit 3 of a 0x55 frame.
        busy_chk = 1'b0;
        wins.delete();
        d55 = 8'h55;
        bus.Prescale = presc_w'(8);
        bus.Par_en   = 1'b0;
        for (int i = 0; i < 35; i++) begin
            bus.RX_in = (i < 8) ? 1'b0 : d55[i/8 - 1];
            @(posedge clk);
            #1;
        end
        bus.RX_in = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("abort_p_data", 32'(bus.P_data), 32'(0));
        check("abort_data_valid", 32'(bus.Data_valid), 32'(0));
        check("abort_par_err", 32'(bus.Par_err), 32'(0));
        check("abort_stp_err", 32'(bus.Stp_err), 32'(0));
        check("abort_busy", 32'(bus.Busy), 32'(0));
        rst = 1'b0;
        @(posedge clk);
        #1;
        last_good = 8'h00;
        idle(3);
        busy_chk = 1'b1;
        send_frame(mk(8'hC3, 8, 0, 0, 0, 1, 2, -1, 0, 1, 0, 0));
        idle(20);

        check("scoreboard_drain", 32'(sb.size()), 32'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
